sram_2p_arbiter: RTL and testbench

- Shares one sram_8k_32b instance (single access per cycle, active-low csbn/wsbn, 1-cycle registered read) between two requesters, p0 and p1.
- Each requester gets a valid/ready request channel and a valid/ready response channel.
- Fair round-robin arbitration; per-port 2-entry response FIFO gives full throughput and response backpressure.
- Sits between the core-side ports (e.g. fetch and LSU/DMA) and the SRAM macro.

---
 rtl/sram_2p_arbiter.sv | 145 ++++++++++++++
 tb/tb_sram_2p_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_2p_arbiter.sv
// rtl/sram_2p_arbiter.sv - two-port round-robin arbiter with per-port response FIFOs in front of one SRAM
// Optional macro SRAM_ARB_PERF_EN adds grant and conflict counters.
module sram_2p_arbiter #(
    parameter int AW = 13,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          p0_req_valid,
    output logic          p0_req_ready,
    input  logic          p0_req_write,
    input  logic [AW-1:0] p0_req_addr,
    input  logic [DW-1:0] p0_req_wdata,
    output logic          p0_rsp_valid,
    input  logic          p0_rsp_ready,
    output logic [DW-1:0] p0_rsp_rdata,
    input  logic          p1_req_valid,
    output logic          p1_req_ready,
    input  logic          p1_req_write,
    input  logic [AW-1:0] p1_req_addr,
    input  logic [DW-1:0] p1_req_wdata,
    output logic          p1_rsp_valid,
    input  logic          p1_rsp_ready,
    output logic [DW-1:0] p1_rsp_rdata,
    output logic          sram_csbn,
    output logic          sram_wsbn,
    output logic [AW-1:0] sram_waddr,
    output logic [AW-1:0] sram_raddr,
    output logic [DW-1:0] sram_wdata,
`ifdef SRAM_ARB_PERF_EN
    output logic [31:0]   perf_p0_grants,
    output logic [31:0]   perf_p1_grants,
    output logic [31:0]   perf_conflicts,
`endif
    input  logic [DW-1:0] sram_rdata
);

    logic [1:0]    w_req_valid, w_req_write, w_rsp_ready, w_rsp_valid;
    logic [1:0]    w_pop, w_elig, w_cand, w_grant;
    logic          w_both, w_sel, w_any;
    logic [AW-1:0] w_req_addr  [2];
    logic [DW-1:0] w_req_wdata [2];
    logic [DW-1:0] w_push_data [2];

    logic [1:0]    r_occ [2];
    logic [1:0]    r_head, r_infl, r_isw;
    logic [DW-1:0] r_fifo [2][2];
    logic          r_rr;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;

    assign w_req_valid    = {p1_req_valid, p0_req_valid};
    assign w_req_write    = {p1_req_write, p0_req_write};
    assign w_rsp_ready    = {p1_rsp_ready, p0_rsp_ready};
    assign w_req_addr[0]  = p0_req_addr;
    assign w_req_addr[1]  = p1_req_addr;
    assign w_req_wdata[0] = p0_req_wdata;
    assign w_req_wdata[1] = p1_req_wdata;

    // A port may issue only if its response is guaranteed a FIFO slot, counting this cycle's pop.
    always_comb begin
        w_rsp_valid    = '0;
        w_pop          = '0;
        w_elig         = '0;
        w_push_data[0] = '0;
        w_push_data[1] = '0;
        for (int i = 0; i < 2; i++) begin
            w_rsp_valid[i] = rst_n && (r_occ[i] != 2'd0);
            w_pop[i]       = w_rsp_valid[i] & w_rsp_ready[i];
            w_elig[i]      = ({1'b0, r_occ[i]} + {2'b00, r_infl[i]}) < (3'd2 + {2'b00, w_pop[i]});
            w_push_data[i] = r_isw[i] ? '0 : sram_rdata;
        end
    end

    assign w_cand  = w_req_valid & w_elig & {2{rst_n}};
    assign w_both  = &w_cand;
    assign w_grant = w_both ? (r_rr ? 2'b10 : 2'b01) : w_cand;
    assign w_sel   = w_grant[1];
    assign w_any   = |w_grant;

    assign p0_req_ready = w_grant[0];
    assign p1_req_ready = w_grant[1];
    assign p0_rsp_valid = w_rsp_valid[0];
    assign p1_rsp_valid = w_rsp_valid[1];
    assign p0_rsp_rdata = r_fifo[0][r_head[0]];
    assign p1_rsp_rdata = r_fifo[1][r_head[1]];

    assign sram_csbn  = ~w_any;
    assign sram_wsbn  = ~(w_any & w_req_write[w_sel]);
    assign sram_waddr = w_any ? w_req_addr[w_sel] : r_addr;
    assign sram_raddr = sram_waddr;
    assign sram_wdata = w_any ? w_req_wdata[w_sel] : r_wdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr     <= 1'b0;
            r_infl   <= '0;
            r_isw    <= '0;
            r_head   <= '0;
            r_occ[0] <= '0;
            r_occ[1] <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else begin
            if (w_both) begin
                r_rr <= ~r_rr;
            end
            r_infl <= w_grant;
            r_isw  <= w_grant & w_req_write;
            if (w_any) begin
                r_addr  <= w_req_addr[w_sel];
                r_wdata <= w_req_wdata[w_sel];
            end
            // Write slot is head+occ; occupancy never reaches 2 while a push is pending.
            for (int i = 0; i < 2; i++) begin
                if (r_infl[i]) begin
                    r_fifo[i][r_head[i] ^ r_occ[i][0]] <= w_push_data[i];
                end
                r_head[i] <= r_head[i] ^ w_pop[i];
                r_occ[i]  <= r_occ[i] + {1'b0, r_infl[i]} - {1'b0, w_pop[i]};
            end
        end
    end

`ifdef SRAM_ARB_PERF_EN
    logic [31:0] r_perf_g0, r_perf_g1, r_perf_conf;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_g0   <= '0;
            r_perf_g1   <= '0;
            r_perf_conf <= '0;
        end else begin
            r_perf_g0   <= r_perf_g0 + {31'd0, w_grant[0]};
            r_perf_g1   <= r_perf_g1 + {31'd0, w_grant[1]};
            r_perf_conf <= r_perf_conf + {31'd0, w_both};
        end
    end

    assign perf_p0_grants = r_perf_g0;
    assign perf_p1_grants = r_perf_g1;
    assign perf_conflicts = r_perf_conf;
`endif

endmodule

// File: tb/tb_sram_2p_arbiter.sv
// tb/tb_sram_2p_arbiter.sv - directed self-checking bench for sram_2p_arbiter with a behavioural SRAM
module tb_sram_2p_arbiter;

    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          p0_req_valid, p0_req_ready, p0_req_write, p0_rsp_valid, p0_rsp_ready;
    logic [AW-1:0] p0_req_addr;
    logic [DW-1:0] p0_req_wdata, p0_rsp_rdata;
    logic          p1_req_valid, p1_req_ready, p1_req_write, p1_rsp_valid, p1_rsp_ready;
    logic [AW-1:0] p1_req_addr;
    logic [DW-1:0] p1_req_wdata, p1_rsp_rdata;
    logic          sram_csbn, sram_wsbn;
    logic [AW-1:0] sram_waddr, sram_raddr;
    logic [DW-1:0] sram_wdata, sram_rdata;
`ifdef SRAM_ARB_PERF_EN
    logic [31:0]   perf_p0_grants, perf_p1_grants, perf_conflicts;
`endif

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] mem [0:8191];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!sram_csbn) begin
            if (!sram_wsbn) mem[sram_waddr] <= sram_wdata;
            else            sram_rdata      <= mem[sram_raddr];
        end
    end

    sram_2p_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_write(p0_req_write),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata), .p0_rsp_valid(p0_rsp_valid),
        .p0_rsp_ready(p0_rsp_ready), .p0_rsp_rdata(p0_rsp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_write(p1_req_write),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata), .p1_rsp_valid(p1_rsp_valid),
        .p1_rsp_ready(p1_rsp_ready), .p1_rsp_rdata(p1_rsp_rdata),
        .sram_csbn(sram_csbn), .sram_wsbn(sram_wsbn), .sram_waddr(sram_waddr),
        .sram_raddr(sram_raddr), .sram_wdata(sram_wdata),
`ifdef SRAM_ARB_PERF_EN
        .perf_p0_grants(perf_p0_grants), .perf_p1_grants(perf_p1_grants),
        .perf_conflicts(perf_conflicts),
`endif
        .sram_rdata(sram_rdata)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        p0_req_valid = 0; p0_req_write = 0; p0_req_addr = '0; p0_req_wdata = '0; p0_rsp_ready = 1;
        p1_req_valid = 0; p1_req_write = 0; p1_req_addr = '0; p1_req_wdata = '0; p1_rsp_ready = 1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        p0_req_valid = 1;
        p1_req_valid = 1;
        cyc();
        cyc();
        #1;
        checks++; if (p0_req_ready !== 1'b0) begin errors++; $display("FAIL reset_p0_ready: got %b expected 0", p0_req_ready); end
        checks++; if (p1_req_ready !== 1'b0) begin errors++; $display("FAIL reset_p1_ready: got %b expected 0", p1_req_ready); end
        checks++; if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b%b expected 00", p1_rsp_valid, p0_rsp_valid); end
        checks++; if (sram_csbn !== 1'b1 || sram_wsbn !== 1'b1) begin errors++; $display("FAIL reset_sram_ctl: got csbn=%b wsbn=%b expected 1 1", sram_csbn, sram_wsbn); end
`ifdef SRAM_ARB_PERF_EN
        checks++; if (perf_p0_grants !== 0 || perf_conflicts !== 0) begin errors++; $display("FAIL reset_perf: got %0d %0d expected 0 0", perf_p0_grants, perf_conflicts); end
`endif
        rst_n = 1;
        idle();
    endtask

    task automatic test_write();
        cyc();
        p0_req_valid = 1; p0_req_write = 1; p0_req_addr = 13'h0010; p0_req_wdata = 32'hDEADBEEF;
        #1;
        checks++; if (p0_req_ready !== 1'b1) begin errors++; $display("FAIL wr_ready: got %b expected 1", p0_req_ready); end
        checks++; if (sram_csbn !== 1'b0 || sram_wsbn !== 1'b0) begin errors++; $display("FAIL wr_sram_ctl: got csbn=%b wsbn=%b expected 0 0", sram_csbn, sram_wsbn); end
        checks++; if (sram_waddr !== 13'h0010 || sram_raddr !== 13'h0010) begin errors++; $display("FAIL wr_addr: got %h/%h expected 0010", sram_waddr, sram_raddr); end
        checks++; if (sram_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_wdata: got %h expected deadbeef", sram_wdata); end
        cyc();
        p0_req_valid = 0;
        #1;
        checks++; if (p0_rsp_valid !== 1'b0 || sram_csbn !== 1'b1) begin errors++; $display("FAIL wr_t1: got rsp_valid=%b csbn=%b expected 0 1", p0_rsp_valid, sram_csbn); end
        cyc();
        checks++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'h0) begin errors++; $display("FAIL wr_ack: got valid=%b data=%h expected 1 0", p0_rsp_valid, p0_rsp_rdata); end
        cyc();
        checks++; if (p0_rsp_valid !== 1'b0) begin errors++; $display("FAIL wr_after_pop: got %b expected 0", p0_rsp_valid); end
    endtask

    task automatic test_read();
        cyc();
        p0_req_valid = 1; p0_req_write = 0; p0_req_addr = 13'h0010;
        #1;
        checks++; if (p0_req_ready !== 1'b1 || sram_wsbn !== 1'b1 || sram_csbn !== 1'b0) begin errors++; $display("FAIL rd_issue: got ready=%b csbn=%b wsbn=%b expected 1 0 1", p0_req_ready, sram_csbn, sram_wsbn); end
        cyc();
        p0_req_valid = 0;
        cyc();
        checks++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data: got valid=%b data=%h expected 1 deadbeef", p0_rsp_valid, p0_rsp_rdata); end
    endtask

    task automatic test_stream();
        for (int ph = 0; ph < 2; ph++) begin
            for (int c = 0; c < 10; c++) begin
                cyc();
                p0_req_valid = (c < 8);
                p0_req_write = (ph == 0);
                p0_req_addr  = 13'(c);
                p0_req_wdata = 32'h1000 + 32'(c);
                #1;
                if (c < 8) begin
                    checks++; if (p0_req_ready !== 1'b1) begin errors++; $display("FAIL stream_ready ph%0d c%0d: got %b expected 1", ph, c, p0_req_ready); end
                end
                if (c >= 2) begin
                    checks++;
                    if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== ((ph == 0) ? 32'h0 : 32'h1000 + 32'(c - 2))) begin
                        errors++;
                        $display("FAIL stream_rsp ph%0d c%0d: got valid=%b data=%h expected 1 %h", ph, c, p0_rsp_valid, p0_rsp_rdata, (ph == 0) ? 32'h0 : 32'h1000 + 32'(c - 2));
                    end
                end
            end
        end
        cyc();
        checks++; if (p0_rsp_valid !== 1'b0) begin errors++; $display("FAIL stream_drained: got %b expected 0", p0_rsp_valid); end
    endtask

    task automatic test_contention();
        int n0, n1, r0, r1;
        n0 = 0; n1 = 0; r0 = 0; r1 = 0;
        idle();
        rst_n = 0;
        cyc();
        rst_n = 1;
        for (int c = 0; c < 13; c++) begin
            cyc();
            p0_req_valid = (c < 10); p0_req_addr = 13'(n0);
            p1_req_valid = (c < 10); p1_req_addr = 13'(7 - n1);
            #1;
            if (c < 10) begin
                checks++;
                if (p0_req_ready !== (c % 2 == 0) || p1_req_ready !== (c % 2 == 1)) begin
                    errors++; $display("FAIL contention_grant c%0d: got p0=%b p1=%b expected p0=%b", c, p0_req_ready, p1_req_ready, c % 2 == 0);
                end
            end
            if (p0_rsp_valid) begin
                checks++; if (p0_rsp_rdata !== 32'h1000 + 32'(r0)) begin errors++; $display("FAIL contention_p0_rsp %0d: got %h expected %h", r0, p0_rsp_rdata, 32'h1000 + 32'(r0)); end
                r0++;
            end
            if (p1_rsp_valid) begin
                checks++; if (p1_rsp_rdata !== 32'h1000 + 32'(7 - r1)) begin errors++; $display("FAIL contention_p1_rsp %0d: got %h expected %h", r1, p1_rsp_rdata, 32'h1000 + 32'(7 - r1)); end
                r1++;
            end
            if (p0_req_valid && p0_req_ready) n0++;
            if (p1_req_valid && p1_req_ready) n1++;
        end
        checks++; if (n0 != 5 || n1 != 5) begin errors++; $display("FAIL contention_counts: got %0d/%0d expected 5/5", n0, n1); end
        checks++; if (r0 != 5 || r1 != 5) begin errors++; $display("FAIL contention_rsp_counts: got %0d/%0d expected 5/5", r0, r1); end
`ifdef SRAM_ARB_PERF_EN
        checks++; if (perf_conflicts !== 32'd10) begin errors++; $display("FAIL perf_conflicts: got %0d expected 10", perf_conflicts); end
        checks++; if (perf_p0_grants !== 32'd5 || perf_p1_grants !== 32'd5) begin errors++; $display("FAIL perf_grants: got %0d/%0d expected 5/5", perf_p0_grants, perf_p1_grants); end
`endif
        idle();
    endtask

    task automatic test_backpressure();
        logic [31:0] q0 [$];
        logic [31:0] q1 [$];
        int a0, a1, r1;
        a0 = 0; a1 = 0; r1 = 0;
        idle();
        rst_n = 0;
        cyc();
        rst_n = 1;
        for (int c = 0; c < 20; c++) begin
            cyc();
            p0_req_valid = (c < 8); p0_req_addr = 13'(a0 % 8);
            p1_rsp_ready = (c >= 8);
            p1_req_valid = (c < 8) || (a1 < 6); p1_req_addr = 13'(a1);
            #1;
            if (c >= 4 && c < 8) begin
                checks++; if (p1_req_ready !== 1'b0 || p0_req_ready !== 1'b1) begin errors++; $display("FAIL bp_stall c%0d: got p0=%b p1=%b expected 1 0", c, p0_req_ready, p1_req_ready); end
            end
            if (p0_rsp_valid) begin
                checks++;
                if (q0.size() == 0 || p0_rsp_rdata !== q0[0]) begin errors++; $display("FAIL bp_p0_rsp c%0d: got %h expected %h", c, p0_rsp_rdata, (q0.size() == 0) ? 32'hx : q0[0]); end
                if (q0.size() != 0) void'(q0.pop_front());
            end
            if (p1_rsp_valid && p1_rsp_ready) begin
                checks++;
                if (q1.size() == 0 || p1_rsp_rdata !== q1[0]) begin errors++; $display("FAIL bp_p1_rsp c%0d: got %h expected %h", c, p1_rsp_rdata, (q1.size() == 0) ? 32'hx : q1[0]); end
                if (q1.size() != 0) void'(q1.pop_front());
                r1++;
            end
            if (p0_req_valid && p0_req_ready) begin q0.push_back(32'h1000 + 32'(a0 % 8)); a0++; end
            if (p1_req_valid && p1_req_ready) begin q1.push_back(32'h1000 + 32'(a1)); a1++; end
            if (c == 7) begin
                checks++; if (a1 != 2) begin errors++; $display("FAIL bp_p1_accepts: got %0d expected 2", a1); end
            end
        end
        checks++; if (a1 != 6 || r1 != 6 || q0.size() != 0 || q1.size() != 0) begin errors++; $display("FAIL bp_drain: got a1=%0d r1=%0d q0=%0d q1=%0d expected 6 6 0 0", a1, r1, q0.size(), q1.size()); end
        idle();
    endtask

    task automatic test_top_addr();
        cyc();
        p0_req_valid = 1; p0_req_write = 1; p0_req_addr = 13'h1FFF; p0_req_wdata = 32'hCAFEF00D;
        #1;
        checks++; if (p0_req_ready !== 1'b1 || sram_waddr !== 13'h1FFF || sram_wsbn !== 1'b0) begin errors++; $display("FAIL top_wr: got ready=%b addr=%h wsbn=%b expected 1 1fff 0", p0_req_ready, sram_waddr, sram_wsbn); end
        cyc();
        p0_req_write = 0;
        #1;
        checks++; if (p0_req_ready !== 1'b1 || sram_raddr !== 13'h1FFF || sram_wsbn !== 1'b1) begin errors++; $display("FAIL top_rd: got ready=%b addr=%h wsbn=%b expected 1 1fff 1", p0_req_ready, sram_raddr, sram_wsbn); end
        cyc();
        p0_req_addr = 13'h0000;
        #1;
        checks++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'h0) begin errors++; $display("FAIL top_wr_ack: got valid=%b data=%h expected 1 0", p0_rsp_valid, p0_rsp_rdata); end
        cyc();
        p0_req_valid = 0;
        #1;
        checks++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL top_rd_data: got valid=%b data=%h expected 1 cafef00d", p0_rsp_valid, p0_rsp_rdata); end
        cyc();
        checks++; if (p0_rsp_valid !== 1'b1 || p0_rsp_rdata !== 32'h1000) begin errors++; $display("FAIL top_no_wrap: got valid=%b data=%h expected 1 00001000", p0_rsp_valid, p0_rsp_rdata); end
    endtask

    task automatic test_reset_mid();
        idle();
        cyc();
        p0_rsp_ready = 0;
        p0_req_valid = 1; p0_req_addr = 13'h1;
        #1;
        checks++; if (p0_req_ready !== 1'b1) begin errors++; $display("FAIL rm_c0: got %b expected 1", p0_req_ready); end
        cyc();
        checks++; if (p0_req_ready !== 1'b1) begin errors++; $display("FAIL rm_c1: got %b expected 1", p0_req_ready); end
        cyc();
        p1_req_valid = 1; p1_req_addr = 13'h2;
        #1;
        checks++; if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b1) begin errors++; $display("FAIL rm_c2: got p0=%b p1=%b expected 0 1", p0_req_ready, p1_req_ready); end
        cyc();
        rst_n = 0;
        #1;
        checks++; if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_rst_rsp: got %b%b expected 00", p1_rsp_valid, p0_rsp_valid); end
        checks++; if (p0_req_ready !== 1'b0 || p1_req_ready !== 1'b0 || sram_csbn !== 1'b1) begin errors++; $display("FAIL rm_rst_req: got p0=%b p1=%b csbn=%b expected 0 0 1", p0_req_ready, p1_req_ready, sram_csbn); end
        cyc();
        rst_n = 1;
        idle();
        #1;
        checks++; if (p0_rsp_valid !== 1'b0 || p1_rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_after: got %b%b expected 00", p1_rsp_valid, p0_rsp_valid); end
        cyc();
        p1_req_valid = 1; p1_req_addr = 13'h3;
        #1;
        checks++; if (p1_req_ready !== 1'b1) begin errors++; $display("FAIL rm_p1_issue: got %b expected 1", p1_req_ready); end
        cyc();
        p1_req_valid = 0;
        #1;
        checks++; if (p1_rsp_valid !== 1'b0) begin errors++; $display("FAIL rm_p1_t1: got %b expected 0", p1_rsp_valid); end
        cyc();
        checks++; if (p1_rsp_valid !== 1'b1 || p1_rsp_rdata !== 32'h1003) begin errors++; $display("FAIL rm_p1_data: got valid=%b data=%h expected 1 00001003", p1_rsp_valid, p1_rsp_rdata); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        rst_n = 0;
        idle();
        test_reset();
        test_write();
        test_read();
        test_stream();
        test_contention();
        test_backpressure();
        test_top_addr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
